des_key_scheduler: RTL
======================

# des_key_scheduler

Iterative DES key-schedule sequencer. It accepts one 64-bit key per job, applies PC-1, then steps the 28-bit C/D halves through the 16-round rotation schedule, emitting one 48-bit PC-2 round key per round over a valid/ready handshake. Encrypt mode emits K1..K16 with left rotations; decrypt mode emits K16..K1 with right rotations. It feeds the iterative Feistel round datapath and replaces sixteen unrolled per-round key generators with one shared register pair.

## Interface
- `KEY_W`, 64, input key width including parity bits; fixed by DES.
- `RK_W`, 48, round key width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  job request; accepted only when `busy_o`=0.
- `decrypt_i`  in  1  direction, sampled with `start_i`: 0=encrypt order, 1=decrypt order.
- `key_i`  in  64  DES key, sampled with `start_i`; bit 63 is DES bit 1; parity bits ignored.
- `busy_o`  out  1  high from the cycle after acceptance through the `done_o` cycle.
- `rk_valid_o`  out  1  `rk_o` holds a valid round key.
- `rk_ready_i`  in  1  consumer accepts `rk_o` when `rk_valid_o`&`rk_ready_i`.
- `rk_o`  out  48  current round key, PC-2 output; bit 47 is DES bit 1.
- `rk_idx_o`  out  4  DES round number minus 1 (0..15) of `rk_o`: ascending for encrypt, descending for decrypt.
- `done_o`  out  1  one-cycle pulse after the final round key handshake.

## Operation
- Shift table `s[0..15]` = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- States: IDLE, RUN, DONE.
- IDLE: `start_i`=1 loads C/D from PC-1(`key_i`), latches the direction and goes to RUN.
  - Encrypt: the load applies a left rotation of `s[0]`.
  - Decrypt: the load applies no rotation.
- RUN, step j = 0..15:
  - `rk_o` = PC-2(C‖D) of the current registers.
  - Encrypt: `rk_idx_o` = j.
  - Decrypt: `rk_idx_o` = 15−j.
- On a handshake with j < 15, C and D each rotate (28-bit wrap) and j increments.
  - Encrypt: left by `s[j+1]`.
  - Decrypt: right by `s[15−j]`.
- On a handshake with j = 15, go to DONE.
- Without a handshake, C/D, j and all outputs hold stable.
- DONE: `done_o`=1 for one cycle, then IDLE.
  - `start_i` in DONE is ignored.
  - A new job can be accepted on the following cycle.
- Rotation invariant: total rotation over a job is 28 positions.
  - Encrypt: after the 16th rotation C/D equals PC-1(key).
  - Decrypt: total right rotation at the last step is 27, one position short of the PC-1 value.
- `start_i` while busy is ignored; the running job is unaffected and `key_i` is not re-sampled.
- `decrypt_i` and `key_i` are don't-care except in the accepting cycle.

## Timing
- Reset values:
  - state = IDLE.
  - `busy_o`=0, `rk_valid_o`=0, `done_o`=0.
  - `rk_o`=0, `rk_idx_o`=0.
  - C/D = 0.
- Reset asserted mid-job aborts immediately: no `done_o` and no further keys.
- Acceptance at edge T: `rk_valid_o`=1 with the first key from T+1. The PC-2 output is registered.
- With `rk_ready_i` held high:
  - One key per cycle, keys at T+1..T+16.
  - `done_o` at T+17.
  - Earliest next acceptance at T+18.
- The handshake on the 16th key drops `rk_valid_o` in the next cycle.
- `rk_valid_o` never deasserts without a handshake. `rk_o` and `rk_idx_o` are stable while valid and not ready.
- All outputs are registered. There is no combinational path from `rk_ready_i` or `start_i` to any output.

## Structure
- Shared package `des_pkg` holds:
  - `SHIFT_SCHED` (16×2-bit).
  - The PC-1 table and a `des_dir_t` enum (ENCRYPT, DECRYPT).
  - The `ks_state_t` enum (IDLE, RUN, DONE).
  - Width constants: 64/56/48/28.
- Sub-modules:
  - PC-2 reuses the existing `p_box_56_48` instance on C‖D.
  - PC-1 is a new combinational `p_box_64_56` driven from `des_pkg`.
- Rotation is a function in `des_pkg`: rotl28/rotr28 by 1 or 2.

## Test plan
- Encrypt, key 0x133457799BBCDFF1, `rk_ready_i`=1 → 16 keys on consecutive cycles:
  - K1 = 0x1B02EFFC7072 with `rk_idx_o`=0.
  - K16 = 0xCB3D8B0E17F5 with `rk_idx_o`=15.
  - `done_o` pulses 17 cycles after acceptance.
- Decrypt, same key → first key 0xCB3D8B0E17F5 (`rk_idx_o`=15), last key 0x1B02EFFC7072 (`rk_idx_o`=0). The sequence is exactly the reverse of the encrypt sequence.
- Random `rk_ready_i` (~50%) → identical key sequence as the ready=1 run. `rk_o` and `rk_idx_o` are stable across stalls. Exactly 16 handshakes.
- `start_i` pulsed with a different key during RUN and in DONE → ignored; the sequence matches the original key and `busy_o` drops only after `done_o`.
- `rst` asserted after the 5th handshake → outputs zero immediately and the FSM is in IDLE. A fresh start produces the full 16-key sequence from K1.
- Back-to-back jobs (start held high) → the second job is accepted exactly two cycles after the 16th handshake (DONE cycle, then IDLE) and its keys are correct.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: widths, permutation tables, rotation schedule and
// the 28-bit rotation helpers used by the key scheduler.
package des_pkg;

    localparam int unsigned KEY_W  = 64;
    localparam int unsigned CD_W   = 56;
    localparam int unsigned RK_W   = 48;
    localparam int unsigned HALF_W = 28;

    typedef enum logic {ENCRYPT = 1'b0, DECRYPT = 1'b1} des_dir_t;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} ks_state_t;

    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Entries are DES bit numbers (1 = MSB); entry 0 drives the output MSB.
    localparam int unsigned PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [RK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Schedule amounts are only ever 1 or 2.
    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        amt);
        return (amt == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                             : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        amt);
        return (amt == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                             : {x[0], x[HALF_W-1:1]};
    endfunction

endpackage

// File: rtl/p_box_56_48.sv
// DES permuted choice 2: compresses the 56-bit C||D pair into a 48-bit round key.
module p_box_56_48
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd_i,
    output logic [RK_W-1:0] rk_o
);

    for (genvar i = 0; i < RK_W; i++) begin : g_pc2
        assign rk_o[RK_W-1-i] = cd_i[CD_W-PC2_TAB[i]];
    end

    // DES bits 9, 18, 22, 25, 35, 38, 43, 54 of C||D are not selected by PC-2.
    logic unused_dropped;
    assign unused_dropped = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                              cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/p_box_64_56.sv
// DES permuted choice 1: selects the 56 key bits from a 64-bit key, dropping parity.
module p_box_64_56
    import des_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    output logic [CD_W-1:0]  cd_o
);

    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign cd_o[CD_W-1-i] = key_i[KEY_W-PC1_TAB[i]];
    end

    // DES bits 8, 16, ..., 64 are parity and take no part in the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8], key_i[0]};

endmodule

// File: rtl/des_key_scheduler.sv
// Iterative DES key schedule: one C/D register pair stepped through 16 rotations,
// emitting a registered PC-2 round key per round over a valid/ready handshake.
module des_key_scheduler
    import des_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             decrypt_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             busy_o,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic [RK_W-1:0]  rk_o,
    output logic [3:0]       rk_idx_o,
    output logic             done_o
);

    ks_state_t         state_q, state_d;
    des_dir_t          dir_q, dir_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
    logic [3:0]        j_q, j_d, idx_q, idx_d;
    logic              busy_q, busy_d, valid_q, valid_d, done_q, done_d;
    logic [RK_W-1:0]   rk_q, rk_d, rk_next;
    logic [CD_W-1:0]   pc1_cd;
    logic              rk_load;

    p_box_64_56 u_pc1 (
        .key_i (key_i),
        .cd_o  (pc1_cd)
    );

    // PC-2 looks at the next-state halves so the key lands in rk_q with the C/D update.
    p_box_56_48 u_pc2 (
        .cd_i ({c_d, d_d}),
        .rk_o (rk_next)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        c_d     = c_q;
        d_d     = d_q;
        j_d     = j_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        rk_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    rk_load = 1'b1;
                    j_d     = 4'd0;
                    if (decrypt_i) begin
                        dir_d = DECRYPT;
                        c_d   = pc1_cd[CD_W-1:HALF_W];
                        d_d   = pc1_cd[HALF_W-1:0];
                        idx_d = 4'd15;
                    end else begin
                        dir_d = ENCRYPT;
                        c_d   = rotl28(pc1_cd[CD_W-1:HALF_W], SHIFT_SCHED[0]);
                        d_d   = rotl28(pc1_cd[HALF_W-1:0], SHIFT_SCHED[0]);
                        idx_d = 4'd0;
                    end
                end
            end
            RUN: begin
                if (rk_ready_i) begin
                    if (j_q == 4'd15) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        j_d     = j_q + 4'd1;
                        rk_load = 1'b1;
                        if (dir_q == ENCRYPT) begin
                            c_d   = rotl28(c_q, SHIFT_SCHED[j_q + 4'd1]);
                            d_d   = rotl28(d_q, SHIFT_SCHED[j_q + 4'd1]);
                            idx_d = idx_q + 4'd1;
                        end else begin
                            c_d   = rotr28(c_q, SHIFT_SCHED[4'd15 - j_q]);
                            d_d   = rotr28(d_q, SHIFT_SCHED[4'd15 - j_q]);
                            idx_d = idx_q - 4'd1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rk_d = rk_load ? rk_next : rk_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= ENCRYPT;
            c_q     <= '0;
            d_q     <= '0;
            j_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            rk_q    <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            c_q     <= c_d;
            d_q     <= d_d;
            j_q     <= j_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            rk_q    <= rk_d;
        end
    end

    assign busy_o     = busy_q;
    assign rk_valid_o = valid_q;
    assign rk_o       = rk_q;
    assign rk_idx_o   = idx_q;
    assign done_o     = done_q;

endmodule
